// File: rtl/ppu_types_pkg.sv
// Shared PPU types: mode encoding, background pixel format, pusher states
// and the visible LCD geometry.
package ppu_types_pkg;

    localparam int LCD_W = 160;
    localparam int LCD_H = 144;

    // PPU mode as seen on STAT[1:0]
    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_DRAW   = 2'd3
    } ppu_mode_t;

    // One background pixel as held in the pixel FIFO
    typedef struct packed {
        logic [1:0] color;
    } pixel_t;

    // Pixel pusher line sequencer
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_PUSH    = 2'd2,
        ST_DONE    = 2'd3
    } pusher_state_t;

endpackage

// File: rtl/ppu_util_pkg.sv
// PPU helper functions shared between the BG pusher and the OBJ mixer.
package ppu_util_pkg;

    // Map a 2-bit color index through a DMG-style palette register.
    function automatic logic [1:0] bgp_shade(input logic [7:0] bgp, input logic [1:0] color);
        logic [1:0] shade;
        case (color)
            2'd0:    shade = bgp[1:0];
            2'd1:    shade = bgp[3:2];
            2'd2:    shade = bgp[5:4];
            2'd3:    shade = bgp[7:6];
            default: shade = bgp[1:0];
        endcase
        return shade;
    endfunction

endpackage

// File: rtl/ppu_pixel_pusher_if.sv
// Pixel FIFO read port and framebuffer write port of the pixel pusher.
// master = pusher side (pops the FIFO, writes the framebuffer).
interface ppu_pixel_pusher_if #(
    parameter int FB_AW = 15
);
    import ppu_types_pkg::*;

    logic               fifo_read_en;
    pixel_t             fifo_read_data;
    logic               fifo_empty;

    logic               fb_we;
    logic [FB_AW-1:0]   fb_addr;
    logic [1:0]         fb_data;

    modport master (
        output fifo_read_en,
        input  fifo_read_data,
        input  fifo_empty,
        output fb_we,
        output fb_addr,
        output fb_data
    );

    modport slave (
        input  fifo_read_en,
        output fifo_read_data,
        output fifo_empty,
        input  fb_we,
        input  fb_addr,
        input  fb_data
    );

endinterface

// File: rtl/ppu_pixel_pusher.sv
// Background pixel pusher: pops the BG pixel FIFO during DRAW, drops the
// fine-scroll pixels, maps the rest through BGP and writes one scanline of
// shades into the framebuffer.
module ppu_pixel_pusher
    import ppu_types_pkg::ppu_mode_t, ppu_types_pkg::MODE_DRAW,
           ppu_types_pkg::pusher_state_t, ppu_types_pkg::ST_IDLE,
           ppu_types_pkg::ST_DISCARD, ppu_types_pkg::ST_PUSH,
           ppu_types_pkg::ST_DONE;
    import ppu_util_pkg::bgp_shade;
#(
    parameter int LCD_W = ppu_types_pkg::LCD_W,
    parameter int LCD_H = ppu_types_pkg::LCD_H,
    parameter int FB_AW = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  ppu_mode_t            mode,
    input  logic                 line_start,
    input  logic [7:0]           ly,
    input  logic [2:0]           scx_fine,
    input  logic [7:0]           bgp,
    input  logic                 bg_en,
    input  logic                 stall,
    ppu_pixel_pusher_if.master   bus,
    output logic [7:0]           pixel_x,
    output logic                 line_done
);

    pusher_state_t      r_state;
    pusher_state_t      w_next_state;

    logic [7:0]         r_x;
    logic [2:0]         r_discard;
    logic [7:0]         r_ly_q;

    logic               r_fb_we;
    logic [FB_AW-1:0]   r_fb_addr;
    logic [1:0]         r_fb_data;
    logic               r_line_done;

    logic               w_start;
    logic               w_active;
    logic               w_pop;
    logic               w_abort;
    logic [16:0]        w_addr_full;
    logic [FB_AW-1:0]   w_addr;
    logic [1:0]         w_color;
    logic [1:0]         w_shade;

    // A line_start only counts for visible lines; it restarts from any state.
    assign w_start  = line_start && (ly < 8'(LCD_H));
    assign w_active = (r_state == ST_DISCARD) || (r_state == ST_PUSH);
    assign w_pop    = w_active && !bus.fifo_empty && !stall;
    assign w_abort  = (mode != MODE_DRAW);

    // ly*160 + x without a multiplier: (ly<<7) + (ly<<5) + x.
    assign w_addr_full = {2'b00, r_ly_q, 7'b000_0000}
                       + {4'b0000, r_ly_q, 5'b0_0000}
                       + {9'b0_0000_0000, r_x};
    assign w_addr      = FB_AW'(w_addr_full);

    // With the background disabled every pixel reads as color 0.
    assign w_color = bg_en ? bus.fifo_read_data.color : 2'b00;
    assign w_shade = bgp_shade(bgp, w_color);

    // Line sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: restart beats abort, abort beats line progress.
    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = (scx_fine != 3'd0) ? ST_DISCARD : ST_PUSH;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_IDLE;
                end
                ST_DISCARD: begin
                    if (w_abort) begin
                        w_next_state = ST_IDLE;
                    end else if (w_pop && (r_discard == 3'd1)) begin
                        w_next_state = ST_PUSH;
                    end else begin
                        w_next_state = ST_DISCARD;
                    end
                end
                ST_PUSH: begin
                    if (w_abort) begin
                        w_next_state = ST_IDLE;
                    end else if (w_pop && (r_x == 8'(LCD_W - 1))) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_PUSH;
                    end
                end
                ST_DONE: begin
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Line counters: latch on start, count down discards, count up pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= 8'd0;
            r_discard <= 3'd0;
            r_ly_q    <= 8'd0;
        end else if (w_start) begin
            r_x       <= 8'd0;
            r_discard <= scx_fine;
            r_ly_q    <= ly;
        end else if (w_pop && (r_state == ST_DISCARD)) begin
            r_discard <= r_discard - 3'd1;
        end else if (w_pop && (r_state == ST_PUSH)) begin
            r_x       <= r_x + 8'd1;
        end else begin
            r_x       <= r_x;
        end
    end

    // Framebuffer write port: one registered write per PUSH pop.
    // A pop coinciding with a restart belongs to the dropped line and is not written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= 2'b00;
        end else if (!w_start && w_pop && (r_state == ST_PUSH)) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= w_addr;
            r_fb_data <= w_shade;
        end else begin
            r_fb_we   <= 1'b0;
        end
    end

    // End-of-line pulse, one cycle after the last write became visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_done <= 1'b0;
        end else begin
            r_line_done <= (r_state == ST_DONE) && !w_start;
        end
    end

    assign bus.fifo_read_en = w_pop;
    assign bus.fb_we        = r_fb_we;
    assign bus.fb_addr      = r_fb_addr;
    assign bus.fb_data      = r_fb_data;
    assign pixel_x          = r_x;
    assign line_done        = r_line_done;

endmodule

// File: doc/ppu_pixel_pusher.md
# ppu_pixel_pusher

Consumer end of the background pixel FIFO. During mode 3 (DRAW) it pops pixels from the FIFO and discards the first `SCX & 7` pixels for fine scroll. It maps each remaining pixel's color index through BGP and writes 160 shades per scanline into the framebuffer. It owns the Framebuffer side of the FIFO and rendering-control protocols: it drives `pixel_x` to the fetchers and honours `stall` from the OBJ fetcher.

## Interface
Parameters:
- `LCD_W`, default 160: pixels per line.
- `LCD_H`, default 144: visible lines.
- `FB_AW`, default 15: framebuffer address width; must satisfy 2^FB_AW ≥ LCD_W·LCD_H.

Ports:
- `clk` in 1: PPU clock. One clock domain; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode` in ppu_mode_t: current PPU mode.
- `line_start` in 1: single-cycle pulse on entry to DRAW.
- `ly` in 8: current scanline.
- `scx_fine` in 3: `SCX[2:0]`, sampled at `line_start`.
- `bgp` in 8: BG palette register.
- `bg_en` in 1: `LCDC[0]`.
- `fifo_read_en` out 1: pop strobe.
- `fifo_read_data` in pixel_t: FIFO head, show-ahead (valid whenever `fifo_empty`=0).
- `fifo_empty` in 1: FIFO has no pixels.
- `stall` in 1: OBJ fetch in progress; do not pop.
- `pixel_x` out 8: index of the next pixel to be emitted.
- `fb_we` out 1: framebuffer write strobe.
- `fb_addr` out FB_AW: `ly*LCD_W + x`.
- `fb_data` out 2: shade.
- `line_done` out 1: one-cycle pulse after the 160th pixel of a line is written.

## Operation
- States: IDLE, DISCARD, PUSH, DONE.
- IDLE:
  - On `line_start` with `ly < LCD_H`: latch `discard = scx_fine`, `x = 0`, `ly_q = ly`.
  - Go to DISCARD if `discard ≠ 0`, else PUSH.
  - `line_start` with `ly ≥ LCD_H` is ignored.
- Pop condition `pop = (state ∈ {DISCARD, PUSH}) & !fifo_empty & !stall`. `fifo_read_en = pop`, combinational.
- DISCARD:
  - Each pop decrements `discard`; no framebuffer write.
  - When the pop makes `discard` zero, the next state is PUSH.
- PUSH:
  - Each pop registers a write: `fb_we=1`, `fb_addr = ly_q*160 + x` (computed as `(ly_q<<7)+(ly_q<<5)+x`, zero-extended to FB_AW), `fb_data = bgp[2c+1:2c]`.
  - `c = bg_en ? fifo_read_data.color : 2'b00`.
  - `x` increments on each pop. The pop with `x = LCD_W-1` moves to DONE.
- DONE: assert `line_done` for one cycle, then go to IDLE.
- Abort: if `mode ≠ DRAW` in DISCARD or PUSH, go to IDLE next cycle. Pending pops cease, there is no `line_done`, and an already-registered write still completes.
- `line_start` in any non-IDLE state restarts the line: it re-latches all values and drops the old line.
- `pixel_x = x`; it holds during DISCARD (value 0) and equals 160 in DONE.
- `stall` and `fifo_empty` have equal effect: no pop and no state change. Both may be asserted together.

## Timing
- Reset values: state IDLE, `fifo_read_en` 0 (state-gated), `pixel_x` 0, `fb_we` 0, `fb_addr` 0, `fb_data` 0, `line_done` 0, internal `x`, `discard`, `ly_q` 0.
- Reset mid-line returns to IDLE immediately (asynchronous); no `line_done`.
- Pop-to-write latency: 1 cycle. `fb_*` are registered and valid in the cycle after `fifo_read_en`.
- `line_start` to first pop: 1 cycle (state is registered), provided FIFO is non-empty and not stalled.
- Throughput: one pixel per cycle. The minimum DRAW length is `1 + scx_fine + 160` cycles from `line_start` to the last write; `line_done` follows one cycle after the last write.
- `pixel_x` updates in the same edge as the write registers.

## Structure
- ppu_types_pkg owns:
  - the state enum `pusher_state_t`;
  - `LCD_W` / `LCD_H` constants;
  - the `pixel_t.color` field (2-bit);
  - ppu_mode_t's DRAW encoding.
- ppu_util_pkg owns a function `bgp_shade(bgp, color)` for the palette lookup; the OBJ mixer reuses it.
- Single module; no sub-module. The FIFO itself stays a separate existing block.

## Test plan
- **Basic line:** `ly=0`, `scx_fine=0`, `bgp=8'hE4`, FIFO always full with colors cycling 0,1,2,3 → 160 writes at addresses 0..159 with shades 0,1,2,3 repeating; `line_done` one cycle after the write to 159; `pixel_x` ends at 160.
- **Fine scroll:** `scx_fine=5`, `ly=143` → first five pops produce no writes; first write at `fb_addr` 22880 with the sixth FIFO pixel; 165 pops total.
- **Stall/empty:** toggle `stall` and `fifo_empty` on random cycles → `fifo_read_en` never high while either is set; writes stay contiguous and in order; 160 writes total.
- **bg_en=0 with bgp=8'h1B** → every `fb_data` = 3 regardless of FIFO color.
- **Abort and reset:**
  - Mode leaves DRAW after 50 writes → `fifo_read_en` drops next cycle, no `line_done`.
  - A new `line_start` restarts at `x=0`.
  - Asserting `rst_n=0` mid-PUSH gives all outputs 0 asynchronously.
- **Ignored line:** `line_start` with `ly=150` → no pops, no writes, state stays IDLE.
